counter_address_register_p: RTL and testbench
=============================================

# counter_address_register_p

Parametrised, fully synchronous counter/address register for the pipelined CPU datapath (program counter, stack pointer and transfer pointers). It holds a WIDTH-bit count that can be cleared, loaded from the transfer bus, stepped up or down by STEP on strobe edges, or offset by a bus value. The count is presented through a second output register to the address bus and/or transfer bus under active-low enables. Carry, borrow and zero flags support cascading and pointer compare.

## Interface
- WIDTH, 16: counter, bus and address width in bits (≥2).
- STEP, 1: increment/decrement amount (1 ≤ STEP < 2^WIDTH).
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous functional clear, active high.
- load_n  input  1  load count from Bus, active low, level-sampled.
- add_n  input  1  add Bus value to count, active low, level-sampled.
- inc  input  1  increment strobe; acts on rising edge only.
- dec  input  1  decrement strobe; acts on rising edge only.
- a_addr_n  input  1  drive Addr from output register, active low.
- a_bus_n  input  1  drive Bus from output register, active low.
- Addr  inout  WIDTH  address bus; high-Z unless a_addr_n low.
- Bus  inout  WIDTH  transfer bus; sampled for load/add, driven when a_bus_n low.
- carry  output  1  one-cycle pulse on upward wrap.
- borrow  output  1  one-cycle pulse on downward wrap.
- zero  output  1  output register equals 0.

## Operation
- Edge detect: inc_q/dec_q register inc/dec each cycle; inc_rise = inc & ~inc_q, dec_rise likewise. A strobe held high for N cycles gives exactly one step.
- Count update, priority high to low at each posedge:
  - reset: count ← 0.
  - clear: count ← 0.
  - ~load_n: count ← Bus.
  - ~add_n: count ← (count + Bus) mod 2^WIDTH.
  - inc_rise & dec_rise: no change; no flags.
  - inc_rise: count ← (count + STEP) mod 2^WIDTH.
  - dec_rise: count ← (count − STEP) mod 2^WIDTH.
- Edge detectors update every cycle regardless of which action wins. A suppressed edge is lost, not queued.
- Output register: out_q ← count every cycle. Addr/Bus and zero are derived from out_q only.
- carry: registered and asserted for one cycle when the selected increment or add produces an unsigned carry out of bit WIDTH−1. borrow: the same for a decrement that underflows. Both are 0 for load, clear and reset.
- Self-load: if load_n and a_bus_n are both low, the loaded value is out_q. This is legal and defined.

## Timing
- Reset values: count = 0, out_q = 0, inc_q = dec_q = 1 (a strobe already high at reset release does not step), carry = borrow = 0, zero = 1. Addr/Bus are high-Z whenever their enable is high, including during reset.
- Latency: an action sampled at edge N updates count at N. out_q, Addr, Bus and zero reflect it after edge N+1. carry/borrow are visible after edge N, for one cycle.
- Tri-state enables are combinational: Addr/Bus drive or release in the same cycle the enable changes.
- Reset mid-operation overrides any concurrent load, add or strobe in that cycle.

## Configuration
- COUNTER_ADDRESS_REGISTER_P_ADD_EN defined: the add_n path and its carry generation are present as described.
- Not defined: the add_n port remains but is ignored. Priority continues directly from load to inc/dec, and carry comes only from increments.

## Test plan
- Reset, then load: WIDTH=16, Bus=16'h1234, load_n low for 1 cycle, then a_addr_n low → Addr=16'h1234 from the second edge after load; Addr high-Z while a_addr_n is high.
- Strobe edges: inc held high 5 cycles, then 2 further single-cycle pulses → count advances by 3·STEP; with STEP=4 from 0, Addr=12.
- Wrap and flags: load 16'hFFFF, pulse inc → count 0, carry pulses exactly 1 cycle, zero=1 one cycle later. Then pulse dec → 16'hFFFF, borrow pulses.
- Priority and simultaneous events: load_n low with inc rising → loaded value, no step. inc and dec rising together → no change, no flags. clear with load_n low → 0.
- Add (macro on): count 16'hFFF0, Bus 16'h0020, add_n low 1 cycle → 16'h0010, carry=1. With the macro off, the same stimulus leaves the count at 16'hFFF0.
- Reset with inc held high: assert reset for 2 cycles with inc=1 throughout and release while inc stays high → count stays 0. The next low-to-high on inc increments once.

Source files
------------

// File: rtl/counter_address_register_p.sv
// Counter/address register: clear, load, add, edge-strobed step, tri-state outputs.
// Optional add path enabled by defining COUNTER_ADDRESS_REGISTER_P_ADD_EN.
module counter_address_register_p #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_n,
    input  logic             add_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             a_addr_n,
    input  logic             a_bus_n,
    inout  wire  [WIDTH-1:0] Addr,
    inout  wire  [WIDTH-1:0] Bus,
    output logic             carry,
    output logic             borrow,
    output logic             zero
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_q;
    logic             inc_q, dec_q;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             inc_rise, dec_rise;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   inc_sum, dec_diff;

    assign inc_rise = inc & ~inc_q;
    assign dec_rise = dec & ~dec_q;

    // While we drive Bus ourselves the loaded value is out_q, without relying on the bus resolving.
    assign load_val = a_bus_n ? Bus : out_q;

    assign inc_sum  = {1'b0, count_q} + {1'b0, STEP_W};
    assign dec_diff = {1'b0, count_q} - {1'b0, STEP_W};

`ifdef COUNTER_ADDRESS_REGISTER_P_ADD_EN
    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, count_q} + {1'b0, Bus};
`else
    logic unused_add_n;
    assign unused_add_n = add_n;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (!load_n) begin
            count_d = load_val;
`ifdef COUNTER_ADDRESS_REGISTER_P_ADD_EN
        end else if (!add_n) begin
            count_d = add_sum[WIDTH-1:0];
            carry_d = add_sum[WIDTH];
`endif
        end else if (inc_rise && dec_rise) begin
            count_d = count_q;
        end else if (inc_rise) begin
            count_d = inc_sum[WIDTH-1:0];
            carry_d = inc_sum[WIDTH];
        end else if (dec_rise) begin
            count_d  = dec_diff[WIDTH-1:0];
            borrow_d = dec_diff[WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            out_q    <= '0;
            inc_q    <= 1'b1;   // a strobe already high at reset release must not step
            dec_q    <= 1'b1;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            out_q    <= count_q;
            inc_q    <= inc;
            dec_q    <= dec;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign Addr   = a_addr_n ? 'z : out_q;
    assign Bus    = a_bus_n  ? 'z : out_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign zero   = (out_q == '0);

endmodule

// File: tb/tb_counter_address_register_p.sv
// Self-checking bench for counter_address_register_p (WIDTH=16, STEP=4) against a behavioural model.
module tb_counter_address_register_p;

    localparam int W    = 16;
    localparam int STEP = 4;
    localparam int MOD  = 1 << W;

    logic clock = 1'b0;
    logic reset, clear, load_n, add_n, inc, dec, a_addr_n, a_bus_n;
    logic [W-1:0] bus_val;
    wire  [W-1:0] Addr;
    wire  [W-1:0] Bus;
    logic carry, borrow, zero;

    int checks = 0;
    int errors = 0;

    // Model state: the count, what the outputs show, and the last strobe levels.
    int m_cnt, m_out;
    bit m_pinc, m_pdec, m_carry, m_borrow;

    // The bench drives Bus whenever the DUT does not.
    assign Bus = a_bus_n ? bus_val : 'z;

    always #5 clock = ~clock;

    counter_address_register_p #(.WIDTH(W), .STEP(STEP)) dut (
        .clock(clock), .reset(reset), .clear(clear), .load_n(load_n), .add_n(add_n),
        .inc(inc), .dec(dec), .a_addr_n(a_addr_n), .a_bus_n(a_bus_n),
        .Addr(Addr), .Bus(Bus), .carry(carry), .borrow(borrow), .zero(zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model predicts from current inputs, then DUT outputs are compared after the edge.
    task automatic cyc(input string tag);
        int  nxt, bv;
        bit  ir, dr, c, b;
        bv = a_bus_n ? int'(bus_val) : m_out;
        ir = inc && !m_pinc;
        dr = dec && !m_pdec;
        c = 0; b = 0; nxt = m_cnt;
        if (reset) begin
            nxt = 0;
        end else if (clear) begin
            nxt = 0;
        end else if (!load_n) begin
            nxt = bv;
`ifdef COUNTER_ADDRESS_REGISTER_P_ADD_EN
        end else if (!add_n) begin
            nxt = m_cnt + bv;
            if (nxt >= MOD) begin nxt -= MOD; c = 1; end
`endif
        end else if (ir && dr) begin
            nxt = m_cnt;
        end else if (ir) begin
            nxt = m_cnt + STEP;
            if (nxt >= MOD) begin nxt -= MOD; c = 1; end
        end else if (dr) begin
            nxt = m_cnt - STEP;
            if (nxt < 0) begin nxt += MOD; b = 1; end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            m_out = 0; m_pinc = 1; m_pdec = 1;
        end else begin
            m_out = m_cnt; m_pinc = inc; m_pdec = dec;
        end
        m_cnt = nxt; m_carry = c; m_borrow = b;
        if (!a_addr_n) check({tag, ":addr"}, 32'(Addr), 32'(m_out));
        if (!a_bus_n)  check({tag, ":bus"}, 32'(Bus), 32'(m_out));
        check({tag, ":zero"},   32'(zero),   32'(m_out == 0));
        check({tag, ":carry"},  32'(carry),  32'(m_carry));
        check({tag, ":borrow"}, 32'(borrow), 32'(m_borrow));
    endtask

    task automatic idle();
        reset = 0; clear = 0; load_n = 1; add_n = 1; a_bus_n = 1;
    endtask

    initial begin
        logic [W-1:0] exp_add;
        reset = 1; clear = 0; load_n = 1; add_n = 1; inc = 0; dec = 0;
        a_addr_n = 0; a_bus_n = 1; bus_val = '0;
        m_cnt = 0; m_out = 0; m_pinc = 1; m_pdec = 1; m_carry = 0; m_borrow = 0;

        // Reset state
        cyc("reset0"); cyc("reset1");
        check("reset_addr", 32'(Addr), 32'h0);
        check("reset_zero", 32'(zero), 32'h1);

        // Load 1234, visible on Addr from the second edge
        reset = 0;
        load_n = 0; bus_val = 16'h1234; cyc("load");
        load_n = 1; bus_val = 16'h0000; cyc("load+1");
        check("load_addr", 32'(Addr), 32'h1234);

        // Strobes: held high 5 cycles, then two pulses -> 3*STEP from 0
        clear = 1; cyc("clear"); clear = 0;
        inc = 1; repeat (5) cyc("inc_hold");
        inc = 0; cyc("inc_low");
        inc = 1; cyc("pulse1"); inc = 0; cyc("pulse1_low");
        inc = 1; cyc("pulse2"); inc = 0; cyc("pulse2_low");
        cyc("settle");
        check("strobe_addr", 32'(Addr), 32'd12);

        // Wrap upward and back down
        load_n = 0; bus_val = 16'hFFFC; cyc("load_fffc"); load_n = 1;
        inc = 1; cyc("wrap_inc");
        check("wrap_carry", 32'(carry), 32'h1);
        inc = 0; cyc("wrap_after");
        check("wrap_carry_gone", 32'(carry), 32'h0);
        check("wrap_zero", 32'(zero), 32'h1);
        dec = 1; cyc("wrap_dec");
        check("wrap_borrow", 32'(borrow), 32'h1);
        dec = 0; cyc("wrap_dec_after");
        cyc("wrap_dec_settle");
        check("wrap_dec_addr", 32'(Addr), 32'hFFFC);

        // Load beats an inc edge; inc+dec together do nothing; clear beats load
        load_n = 0; bus_val = 16'h5555; inc = 1; cyc("load_vs_inc");
        load_n = 1; inc = 0; cyc("load_vs_inc+1");
        check("load_vs_inc_addr", 32'(Addr), 32'h5555);
        inc = 1; dec = 1; cyc("inc_dec_both");
        check("both_carry", 32'(carry), 32'h0);
        inc = 0; dec = 0; cyc("inc_dec_low"); cyc("inc_dec_settle");
        check("both_addr", 32'(Addr), 32'h5555);
        clear = 1; load_n = 0; bus_val = 16'hAAAA; cyc("clear_vs_load");
        clear = 0; load_n = 1; cyc("clear_vs_load+1");
        check("clear_vs_load_addr", 32'(Addr), 32'h0);

        // Add with carry out (ignored when the add path is absent)
        load_n = 0; bus_val = 16'hFFF0; cyc("load_fff0"); load_n = 1;
        add_n = 0; bus_val = 16'h0020; cyc("add");
        add_n = 1; cyc("add+1");
`ifdef COUNTER_ADDRESS_REGISTER_P_ADD_EN
        exp_add = 16'h0010;
`else
        exp_add = 16'hFFF0;
`endif
        check("add_addr", 32'(Addr), 32'(exp_add));

        // Self-load while the DUT drives Bus
        a_bus_n = 0; cyc("bus_drive");
        load_n = 0; cyc("self_load"); load_n = 1; a_bus_n = 1;
        cyc("self_load+1");

        // Reset with inc held high: no step at release, next rise steps once
        inc = 1; reset = 1; cyc("rst_inc0"); cyc("rst_inc1");
        reset = 0; cyc("rst_rel0"); cyc("rst_rel1");
        check("rst_inc_addr", 32'(Addr), 32'h0);
        inc = 0; cyc("rst_inc_low");
        inc = 1; cyc("rst_inc_rise"); cyc("rst_inc_rise+1");
        check("rst_inc_step", 32'(Addr), 32'(STEP));
        inc = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            clear    = ($urandom_range(0, 19) == 0);
            load_n   = ($urandom_range(0, 7) != 0);
            add_n    = ($urandom_range(0, 5) != 0);
            inc      = 1'($urandom);
            dec      = 1'($urandom);
            a_bus_n  = ($urandom_range(0, 3) != 0);
            a_addr_n = ($urandom_range(0, 4) == 0);
            bus_val  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 15))
                                                    : 16'($urandom);
            cyc("rand");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
